// File: rtl/wino_tile_gen.sv
// Builds overlapping N-sample tiles from a serial signed sample stream.
// Consecutive tiles step by M samples; a short row tail is zero-padded.
//  state  | meaning
//  FILL   | collecting the first N samples of a row
//  STRIDE | collecting M new samples for the next overlapping tile
//  PAD    | shifting zeros in to finish a short final tile
//  OUT    | tile presented on t_data, waiting for t_ready
module wino_tile_gen #(
  parameter int W = 10,
  parameter int N = 5,
  parameter int M = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_data,
  input  logic           s_last,
  output logic           t_valid,
  input  logic           t_ready,
  output logic [N*W-1:0] t_data,
  output logic           t_last
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {FILL, STRIDE, PAD, OUT} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           pad_q, pad_d;
  logic                    last_q, last_d;
  logic [N-1:0][W-1:0]     sr_q, sr_d;
  logic [CW-1:0]           cnt_inc;
  logic [CW-1:0]           tgt;
  logic                    shift_en;
  logic [W-1:0]            shift_val;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pad_d     = pad_q;
    last_d    = last_q;
    sr_d      = sr_q;
    s_ready   = 1'b0;
    t_valid   = 1'b0;
    t_last    = 1'b0;
    shift_en  = 1'b0;
    shift_val = '0;
    cnt_inc   = cnt_q + 1'b1;
    tgt       = (state_q == FILL) ? CW'(N) : CW'(M);

    case (state_q)
      FILL, STRIDE: begin
        s_ready = !rst;
        if (s_valid && !rst) begin
          shift_en  = 1'b1;
          shift_val = s_data;
          cnt_d     = cnt_inc;
          if (cnt_inc == tgt) begin
            state_d = OUT;
            last_d  = s_last;
          end else if (s_last) begin
            state_d = PAD;
            pad_d   = tgt - cnt_inc;
          end
        end
      end
      PAD: begin
        shift_en = 1'b1;
        pad_d    = pad_q - 1'b1;
        if (pad_q == CW'(1)) begin
          state_d = OUT;
          last_d  = 1'b1;
        end
      end
      OUT: begin
        t_valid = 1'b1;
        t_last  = last_q;
        if (t_ready) begin
          cnt_d = '0;
          if (last_q) begin
            state_d = FILL;
            last_d  = 1'b0;
            sr_d    = '0;
          end else begin
            state_d = STRIDE;
          end
        end
      end
      default: state_d = FILL;
    endcase

    // sr[0] is the oldest sample; new samples (or pad zeros) enter at sr[N-1]
    if (shift_en) begin
      for (int i = 0; i < N - 1; i++) sr_d[i] = sr_q[i+1];
      sr_d[N-1] = shift_val;
    end
  end

  always_comb begin
    t_data = '0;
    for (int i = 0; i < N; i++) t_data[(N-1-i)*W +: W] = sr_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      pad_q   <= '0;
      last_q  <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pad_q   <= pad_d;
      last_q  <= last_d;
      sr_q    <= sr_d;
    end
  end

endmodule

// File: tb/tb_wino_tile_gen.sv
// Directed scenarios plus random rows with random flow control, checked
// against a positional model: tile k of a row holds row samples k*M..k*M+N-1.
module tb_wino_tile_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [9:0]  s_data;
  logic        s_last;
  logic        t_valid;
  logic        t_ready;
  logic [49:0] t_data;
  logic        t_last;

  int total = 0;
  int bad   = 0;

  int          row_q[$];
  int          row_len, n_tiles, idx, ti, cyc, tmp;
  logic [49:0] held;

  wino_tile_gen #(.W(10), .N(5), .M(3)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .t_valid(t_valid), .t_ready(t_ready), .t_data(t_data), .t_last(t_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [49:0] pk(input int a, input int b, input int c, input int d, input int e);
    return {a[9:0], b[9:0], c[9:0], d[9:0], e[9:0]};
  endfunction

  // Model: tile k covers row positions k*3 .. k*3+4, zero beyond the row end.
  function automatic logic [49:0] model_tile(input int k);
    logic [49:0] t;
    int v;
    t = '0;
    for (int i = 0; i < 5; i++) begin
      v = (k * 3 + i < row_q.size()) ? row_q[k*3+i] : 0;
      t = {t[39:0], v[9:0]};
    end
    return t;
  endfunction

  task automatic send(input int d, input bit last);
    s_valid = 1'b1;
    s_data  = d[9:0];
    s_last  = last;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    chk("send_ready", {63'd0, s_ready}, 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic take(input string tag, input logic [49:0] exp, input bit exp_last, input int exp_lat);
    int lat;
    lat = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (t_valid) break;
      lat++;
    end
    chk({tag, "_lat"},   64'(lat), 64'(exp_lat));
    chk({tag, "_valid"}, {63'd0, t_valid}, 64'd1);
    chk({tag, "_data"},  {14'd0, t_data}, {14'd0, exp});
    chk({tag, "_last"},  {63'd0, t_last}, {63'd0, exp_last});
    t_ready = 1'b1;
    @(posedge clk); #1;
    t_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; t_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_t_valid", {63'd0, t_valid}, 64'd0);
    chk("rst_t_data",  {14'd0, t_data}, 64'd0);
    chk("rst_t_last",  {63'd0, t_last}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", {63'd0, s_ready}, 64'd1);
    @(posedge clk); #1;

    // first tile, then two strided tiles
    send(2, 0); send(-10, 0); send(3, 0); send(4, 0);
    chk("t1_pre_valid", {63'd0, t_valid}, 64'd0);
    send(-13, 0);
    take("t1", 50'b0000000010_1111110110_0000000011_0000000100_1111110011, 0, 0);
    send(5, 0); send(6, 0); send(7, 0);
    take("t2a", pk(4, -13, 5, 6, 7), 0, 0);
    send(-1, 0); send(-2, 0); send(-3, 0);

    // backpressure with a sample waiting upstream
    s_valid = 1'b1; s_data = 10'd11; s_last = 1'b0;
    @(negedge clk);
    held = t_data;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_valid",   {63'd0, t_valid}, 64'd1);
      chk("bp_data",    {14'd0, t_data}, {14'd0, held});
      chk("bp_s_ready", {63'd0, s_ready}, 64'd0);
      @(posedge clk); #1;
    end
    t_ready = 1'b1;
    @(negedge clk);
    chk("t2b_data", {14'd0, t_data}, {14'd0, pk(6, 7, -1, -2, -3)});
    @(posedge clk); #1;
    t_ready = 1'b0;
    @(negedge clk);
    chk("bp_once_valid", {63'd0, t_valid}, 64'd0);
    chk("bp_resume",     {63'd0, s_ready}, 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    send(12, 0); send(13, 1);
    take("bp_tail", pk(-2, -3, 11, 12, 13), 1, 0);
    @(negedge clk);
    chk("row_clear", {14'd0, t_data}, 64'd0);
    @(posedge clk); #1;

    // short stride tail: one pad cycle
    send(2, 0); send(-10, 0); send(3, 0); send(4, 0); send(-13, 0);
    take("t3a", pk(2, -10, 3, 4, -13), 0, 0);
    send(5, 0); send(6, 1);
    take("t3b", pk(4, -13, 5, 6, 0), 1, 1);
    @(negedge clk);
    chk("t3_clear",   {14'd0, t_data}, 64'd0);
    chk("t3_s_ready", {63'd0, s_ready}, 64'd1);
    @(posedge clk); #1;

    // short row: two pad cycles; full row ending exactly on N
    send(9, 0); send(8, 0); send(7, 1);
    take("t4a", pk(9, 8, 7, 0, 0), 1, 2);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0); send(5, 1);
    take("t4b", pk(1, 2, 3, 4, 5), 1, 0);

    // reset during STRIDE discards the partial tile
    send(2, 0); send(-10, 0); send(3, 0); send(4, 0); send(-13, 0);
    take("t6a", pk(2, -10, 3, 4, -13), 0, 0);
    send(1, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_s_ready", {63'd0, s_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_valid", {63'd0, t_valid}, 64'd0);
    chk("t6_data",  {14'd0, t_data}, 64'd0);
    send(-19, 0); send(-6, 0); send(3, 0); send(-9, 0);
    chk("t6_need5", {63'd0, t_valid}, 64'd0);
    send(-12, 0);
    take("t6b", 50'b1111101101_1111111010_0000000011_1111110111_1111110100, 0, 0);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // random rows with random valid gaps and backpressure
    for (int r = 0; r < 30; r++) begin
      row_q.delete();
      row_len = $urandom_range(1, 14);
      for (int i = 0; i < row_len; i++) row_q.push_back(int'($urandom_range(0, 1023)) - 512);
      n_tiles = (row_len <= 5) ? 1 : 1 + (row_len - 5 + 2) / 3;
      idx = 0; ti = 0; cyc = 0;
      while ((idx < row_len || ti < n_tiles) && cyc < 500) begin
        s_valid = (idx < row_len) && ($urandom_range(0, 3) != 0);
        tmp     = (idx < row_len) ? row_q[idx] : int'($urandom_range(0, 1023));
        s_data  = tmp[9:0];
        s_last  = (idx == row_len - 1) || ($urandom_range(0, 7) == 0 && idx >= row_len);
        t_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (t_valid) chk("rnd_overlap", {63'd0, s_ready}, 64'd0);
        if (t_valid && t_ready) begin
          chk("rnd_data", {14'd0, t_data}, {14'd0, model_tile(ti)});
          chk("rnd_last", {63'd0, t_last}, {63'd0, ti == n_tiles - 1});
          ti++;
        end
        if (s_valid && s_ready) idx++;
        @(posedge clk); #1;
        cyc++;
      end
      s_valid = 1'b0; s_last = 1'b0; t_ready = 1'b0;
      chk("rnd_tiles",   64'(ti), 64'(n_tiles));
      chk("rnd_samples", 64'(idx), 64'(row_len));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
